alu_column_mac: RTL and testbench
=================================

# alu_column_mac

Multiply-accumulate engine that answers the matrix controller's ALU handshake. Each time `ALU_en` is raised it computes one result column: four parallel dot products of length 8 between coefficient-ROM rows and one column of the loaded X matrix. It then pulses `web` to write the column into result memory. After the fourth column it pulses `ALU_done`, which the controller forwards as `finish`.

## Interface
- `DATA_W`, 8: operand width, unsigned.
- `ROWS`, 4: parallel accumulators, one per result row.
- `K_LEN`, 8: MAC steps per column.
- `COLS`, 4: columns per matrix run.
- `ACC_W`, 2*DATA_W+3 = 19: accumulator width, sized so K_LEN full-scale products cannot overflow.
- Only the default parameter set is verified.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `ALU_en`  in  1  start/hold request from the controller, high during its ALU state.
- `coef_in`  in  ROWS*DATA_W  coefficient ROM data for address `coef_addr`; row r is in bits [r*DATA_W +: DATA_W]; one-cycle read latency.
- `x_in`  in  DATA_W  X element selected by `x_sel`; one-cycle latency.
- `coef_addr`  out  3  ROM address, equal to k.
- `x_sel`  out  5  X element select, {col[1:0], k[2:0]}.
- `web`  out  1  result-memory write strobe, active-high one-cycle pulse.
- `ram_addr`  out  2  result column index, valid with `web`.
- `ram_din`  out  ROWS*ACC_W  packed accumulators; row r is in bits [r*ACC_W +: ACC_W].
- `ALU_done`  out  1  one-cycle pulse after the last column has been written.

## Operation
- **States:** IDLE, RUN, DRAIN, WRITE, HOLD.
- **IDLE:**
  - When `ALU_en`=1 is sampled, clear all accumulators, set k=0 and go to RUN.
  - `col` holds its value from the previous column.
- **RUN:**
  - For 8 cycles, drive `coef_addr`=k and `x_sel`={col,k} with k=0..7.
  - Move to DRAIN after k=7 has been issued.
- **Accumulation:**
  - A one-bit valid pipe follows the issue by one cycle.
  - On each valid cycle, acc[r] <= acc[r] + coef_in[r]*x_in for every row r.
  - Arithmetic is unsigned. Products are 16 bits, zero-extended to ACC_W.
- **DRAIN:** one cycle; accumulates k=7.
- **WRITE:**
  - One cycle with `web`=1, `ram_addr`=col and `ram_din`=acc.
  - `col` <= col+1, wrapping 3->0.
  - Set the `last` flag when the column being written is column 3.
- **HOLD:**
  - Stay until `ALU_en`=0 is sampled, then go to IDLE.
  - This blocks a column from re-triggering off a held `ALU_en`.
  - `ALU_done`=1 in the first HOLD cycle only, and only when `last` is set.
- **`ALU_en` behaviour:**
  - Dropping `ALU_en` during RUN/DRAIN/WRITE is ignored; the column always completes.
  - `ALU_en` high in IDLE with no prior drop is impossible by construction and is treated as a start.
- **Reset (`rst`=0 at any edge):**
  - State returns to IDLE; col=0, k=0, valid=0, acc=0, last=0.
  - Every output goes to 0: `web`, `ALU_done`, `coef_addr`, `x_sel`, `ram_addr`, `ram_din`.
  - A column interrupted mid-run is never written.
- **Output timing:** all outputs are registered; there are no combinational input-to-output paths.

## Timing
- Edge 0 samples `ALU_en`=1. RUN occupies cycles 1-8, DRAIN cycle 9, WRITE cycle 10 (`web`=1), HOLD from cycle 11.
- Latency from `ALU_en` sampled to `web` is 10 cycles.
- **Controller handshake per column:**
  - The controller sees `web` and enters next_col in cycle 11, so `ALU_en`=0.
  - The engine leaves HOLD at the end of cycle 11.
  - `ALU_en` returns high in cycle 12 and is sampled at edge 12; that is edge 0 of the next column.
- Period is 12 cycles per column; a full run is 4 `web` pulses at relative cycles 10, 22, 34, 46.
- `ALU_done` is high in cycle 47 only.

## Test plan
- **Reset:** hold `rst`=0 for 3 cycles with `ALU_en`=1 -> all outputs 0, no `web`; release -> column 0 starts at the next sampled `ALU_en`.
- **Unit column:** coef all 1, x all 1, one `ALU_en` pulse -> `web` exactly 10 cycles later, `ram_addr`=0, each row of `ram_din`=8, then HOLD with `ALU_done`=0.
- **Full scale:** coef=255 and x=255 everywhere -> each row=520200 (0x7F008), no wrap in 19 bits.
- **Full run against the real controller:**
  - Stimulus: coef[r][k]=r+1, x[k][j]=j+1.
  - Required `web` pulses: `ram_addr` 0,1,2,3, with row r = 8(r+1)(j+1).
  - Required `ALU_done`: single pulse one cycle after the 4th `web`; controller `finish` follows; engine back in IDLE with col=0.
- **Reset mid-RUN:** assert `rst`=0 in cycle 5 of column 2 -> no `web`; next `ALU_en` computes column 0 from cleared accumulators.
- **Held `ALU_en`:** keep `ALU_en`=1 for 20 cycles after a `web` -> no second `web`; drop then raise -> next column starts 10 cycles to `web`.

Source files
------------

// File: rtl/alu_column_mac.sv
// alu_column_mac: computes one 4-row result column per ALU_en handshake.
// Each row is an 8-step dot product of a coefficient-ROM row and one X column.
// The finished column is written with a single web pulse. ALU_done pulses
// once, after the fourth column of a matrix run has been written.
module alu_column_mac #(
   parameter int DATA_W = 8,
   parameter int ROWS   = 4,
   parameter int K_LEN  = 8,
   parameter int COLS   = 4,
   parameter int ACC_W  = 2*DATA_W+3
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    ALU_en,
   input  logic [ROWS*DATA_W-1:0]  coef_in,
   input  logic [DATA_W-1:0]       x_in,
   output logic [2:0]              coef_addr,
   output logic [4:0]              x_sel,
   output logic                    web,
   output logic [1:0]              ram_addr,
   output logic [ROWS*ACC_W-1:0]   ram_din,
   output logic                    ALU_done
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RUN   = 3'd1,
      DRAIN = 3'd2,
      WRITE = 3'd3,
      HOLD  = 3'd4
   } state_t;

   state_t     state;
   logic [2:0] k;      // MAC step being issued to the ROM and X memory
   logic [1:0] col;    // result column; survives IDLE between columns
   logic       valid;  // ROM/X data for an issued step is present this cycle
   logic       last;   // the column about to be written is the final one
   logic       start;

   // A start is any sampled ALU_en while idle.
   assign start = (state == IDLE) && ALU_en;

   // The step counter and column index are registers, so these outputs are
   // registered and carry no combinational path from any input.
   assign coef_addr = k;
   assign x_sel     = {col, k};
   assign ram_addr  = col;

   // Sequencer: column control, valid pipe and the write/done strobes.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= IDLE;
         k        <= '0;
         col      <= '0;
         valid    <= 1'b0;
         last     <= 1'b0;
         web      <= 1'b0;
         ALU_done <= 1'b0;
      end else begin
         valid    <= (state == RUN);
         web      <= 1'b0;
         ALU_done <= 1'b0;
         case (state)
            IDLE: begin
               if (ALU_en) begin
                  state <= RUN;
                  k     <= '0;
                  last  <= 1'b0;
               end
            end
            RUN: begin
               if (k == 3'(K_LEN-1)) begin
                  state <= DRAIN;
                  k     <= '0;
               end else begin
                  k <= k + 3'd1;
               end
            end
            DRAIN: begin
               // The final step is accumulated this cycle; the write follows.
               state <= WRITE;
               web   <= 1'b1;
               last  <= (col == 2'(COLS-1));
            end
            WRITE: begin
               state    <= HOLD;
               col      <= col + 2'd1;
               ALU_done <= last;
            end
            HOLD: begin
               // A still-high ALU_en must not retrigger the next column.
               if (!ALU_en) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < ROWS; gi++) begin : g_row
         logic [2*DATA_W-1:0] prod;
         logic [ACC_W-1:0]    acc;

         assign prod = coef_in[gi*DATA_W +: DATA_W] * x_in;
         assign ram_din[gi*ACC_W +: ACC_W] = acc;

         // Per-row accumulator, cleared on start and on reset.
         always_ff @(posedge clk) begin
            if (!rst) begin
               acc <= '0;
            end else if (start) begin
               acc <= '0;
            end else if (valid) begin
               acc <= acc + {{(ACC_W-2*DATA_W){1'b0}}, prod};
            end
         end
      end
   endgenerate

endmodule

// File: tb/tb_alu_column_mac.sv
// Directed testbench for alu_column_mac with a ROM/X memory model that has
// one-cycle read latency and a bench-side controller handshake.
module tb_alu_column_mac;

   logic        clk;
   logic        rst;
   logic        ALU_en;
   logic [31:0] coef_in;
   logic [7:0]  x_in;
   logic [2:0]  coef_addr;
   logic [4:0]  x_sel;
   logic        web;
   logic [1:0]  ram_addr;
   logic [75:0] ram_din;
   logic        ALU_done;

   int checks = 0;
   int errors = 0;

   logic [7:0] coef_mem [8][4];
   logic [7:0] x_mem [32];

   alu_column_mac dut (
      .clk       (clk),
      .rst       (rst),
      .ALU_en    (ALU_en),
      .coef_in   (coef_in),
      .x_in      (x_in),
      .coef_addr (coef_addr),
      .x_sel     (x_sel),
      .web       (web),
      .ram_addr  (ram_addr),
      .ram_din   (ram_din),
      .ALU_done  (ALU_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model: one-cycle read latency.
   always @(posedge clk) begin
      for (int r = 0; r < 4; r++) coef_in[r*8 +: 8] <= coef_mem[coef_addr][r];
      x_in <= x_mem[x_sel];
   end

   // mode 0: all ones, 1: all 255, 2: coef=r+1, x=j+1
   task automatic load(input int mode);
      for (int k = 0; k < 8; k++)
         for (int r = 0; r < 4; r++)
            coef_mem[k][r] = (mode == 0) ? 8'd1 : (mode == 1) ? 8'd255 : 8'(r + 1);
      for (int i = 0; i < 32; i++)
         x_mem[i] = (mode == 0) ? 8'd1 : (mode == 1) ? 8'd255 : 8'((i >> 3) + 1);
   endtask

   task automatic apply_reset();
      rst = 1'b0;
      ALU_en = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   // Controller handshake for one column; returns what was observed.
   // Entered with the next edge being edge 0; leaves in cycle 12 (IDLE).
   task automatic do_column(output int lat, output logic [1:0] addr,
                            output logic [75:0] din, output logic done11,
                            output int stray_done);
      stray_done = 0;
      lat = 0;
      ALU_en = 1'b1;
      do begin
         @(posedge clk); #1;
         lat++;
         if (ALU_done) stray_done++;
      end while (!web && lat < 30);
      addr = ram_addr;
      din = ram_din;
      @(posedge clk); #1;
      done11 = ALU_done;
      ALU_en = 1'b0;
      @(posedge clk); #1;
      if (ALU_done) stray_done++;
      $display("column: latency %0d addr %0d din %h done %0d", lat, addr, din, done11);
   endtask

   task automatic test_reset();
      int lat, stray;
      logic [1:0] addr;
      logic [75:0] din;
      logic d11;
      load(0);
      rst = 1'b0;
      ALU_en = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         checks++;
         if ({web, ALU_done, coef_addr, x_sel, ram_addr, ram_din} !== '0) begin
            errors++;
            $display("FAIL reset_outputs cycle %0d: got web=%b done=%b ca=%0d xs=%0d ra=%0d din=%h, need all 0",
                     c, web, ALU_done, coef_addr, x_sel, ram_addr, ram_din);
         end
      end
      rst = 1'b1;
      do_column(lat, addr, din, d11, stray);
      checks++;
      if (lat !== 10) begin
         errors++;
         $display("FAIL reset_release_latency: got %0d, need 10", lat);
      end
      checks++;
      if (addr !== 2'd0) begin
         errors++;
         $display("FAIL reset_release_addr: got %0d, need 0", addr);
      end
   endtask

   task automatic test_unit_column();
      int lat, stray;
      logic [1:0] addr;
      logic [75:0] din;
      logic d11;
      apply_reset();
      load(0);
      do_column(lat, addr, din, d11, stray);
      checks++;
      if (lat !== 10) begin
         errors++;
         $display("FAIL unit_latency: got %0d, need 10", lat);
      end
      checks++;
      if (addr !== 2'd0) begin
         errors++;
         $display("FAIL unit_addr: got %0d, need 0", addr);
      end
      for (int r = 0; r < 4; r++) begin
         checks++;
         if (din[r*19 +: 19] !== 19'd8) begin
            errors++;
            $display("FAIL unit_row%0d: got %0d, need 8", r, din[r*19 +: 19]);
         end
      end
      checks++;
      if (d11 !== 1'b0 || stray !== 0) begin
         errors++;
         $display("FAIL unit_done: got done11=%b stray=%0d, need 0/0", d11, stray);
      end
   endtask

   task automatic test_full_scale();
      int lat, stray;
      logic [1:0] addr;
      logic [75:0] din;
      logic d11;
      apply_reset();
      load(1);
      do_column(lat, addr, din, d11, stray);
      for (int r = 0; r < 4; r++) begin
         checks++;
         if (din[r*19 +: 19] !== 19'h7F008) begin
            errors++;
            $display("FAIL fullscale_row%0d: got %h, need 7f008", r, din[r*19 +: 19]);
         end
      end
   endtask

   task automatic test_full_run();
      int lat, stray;
      logic [1:0] addr;
      logic [75:0] din;
      logic d11;
      apply_reset();
      load(2);
      for (int j = 0; j < 4; j++) begin
         do_column(lat, addr, din, d11, stray);
         checks++;
         if (lat !== 10 || addr !== 2'(j)) begin
            errors++;
            $display("FAIL run_col%0d_timing: got lat=%0d addr=%0d, need 10/%0d", j, lat, addr, j);
         end
         for (int r = 0; r < 4; r++) begin
            checks++;
            if (din[r*19 +: 19] !== 19'(8*(r+1)*(j+1))) begin
               errors++;
               $display("FAIL run_col%0d_row%0d: got %0d, need %0d",
                        j, r, din[r*19 +: 19], 8*(r+1)*(j+1));
            end
         end
         checks++;
         if (d11 !== (j == 3) || stray !== 0) begin
            errors++;
            $display("FAIL run_col%0d_done: got done11=%b stray=%0d, need %0d/0", j, d11, stray, j == 3);
         end
      end
      checks++;
      if (x_sel !== 5'd0) begin
         errors++;
         $display("FAIL run_wrap_col: got x_sel=%0d, need 0", x_sel);
      end
   endtask

   task automatic test_reset_mid_run();
      int lat, stray, webs;
      logic [1:0] addr;
      logic [75:0] din;
      logic d11;
      apply_reset();
      load(2);
      do_column(lat, addr, din, d11, stray);
      do_column(lat, addr, din, d11, stray);
      ALU_en = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b0;
      ALU_en = 1'b0;
      webs = 0;
      for (int c = 0; c < 2; c++) begin
         @(posedge clk); #1;
         checks++;
         if ({web, ALU_done, coef_addr, x_sel, ram_addr, ram_din} !== '0) begin
            errors++;
            $display("FAIL midrun_reset_outputs: got web=%b ca=%0d xs=%0d ra=%0d din=%h, need all 0",
                     web, coef_addr, x_sel, ram_addr, ram_din);
         end
      end
      rst = 1'b1;
      for (int c = 0; c < 15; c++) begin
         @(posedge clk); #1;
         if (web) webs++;
      end
      checks++;
      if (webs !== 0) begin
         errors++;
         $display("FAIL midrun_no_web: got %0d pulses, need 0", webs);
      end
      do_column(lat, addr, din, d11, stray);
      checks++;
      if (addr !== 2'd0 || din[0 +: 19] !== 19'd8 || din[57 +: 19] !== 19'd32) begin
         errors++;
         $display("FAIL midrun_restart: got addr=%0d row0=%0d row3=%0d, need 0/8/32",
                  addr, din[0 +: 19], din[57 +: 19]);
      end
   endtask

   task automatic test_held_en();
      int lat, stray, webs, n;
      logic [1:0] addr;
      logic [75:0] din;
      logic d11;
      apply_reset();
      load(0);
      ALU_en = 1'b1;
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!web && n < 30);
      checks++;
      if (n !== 10) begin
         errors++;
         $display("FAIL held_first_latency: got %0d, need 10", n);
      end
      webs = 0;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk); #1;
         if (web) webs++;
      end
      checks++;
      if (webs !== 0) begin
         errors++;
         $display("FAIL held_no_retrigger: got %0d pulses, need 0", webs);
      end
      ALU_en = 1'b0;
      @(posedge clk); #1;
      do_column(lat, addr, din, d11, stray);
      checks++;
      if (lat !== 10 || addr !== 2'd1) begin
         errors++;
         $display("FAIL held_next_column: got lat=%0d addr=%0d, need 10/1", lat, addr);
      end
   endtask

   initial begin
      rst = 1'b0;
      ALU_en = 1'b0;
      load(0);
      @(posedge clk); #1;
      test_reset();
      test_unit_column();
      test_full_scale();
      test_full_run();
      test_reset_mid_run();
      test_held_en();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
